// File: rtl/count_isqrt_unit.sv
// count_isqrt_unit
//   Integer square root of a counter sample, computed digit by digit.
//   Each CALC cycle consumes two radicand bits, so a result takes RW cycles.
//   Both sides use valid/ready handshakes.
//   Optional macro ISQRT_ROUND_EN: round root to nearest, saturating at all-ones.
//   When it is undefined, root is the floor root.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   The producer holds valid and its data stable until that transfer.
//   Input side: in_ready is high only in IDLE. in_valid at other times is ignored.
//   Output side: out_valid is high only in DONE. root/rem stay frozen until
//   the consumer takes the result.
//   clear overrides both handshakes in the same cycle.
module count_isqrt_unit #(
    parameter int BITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [BITS-1:0]     in_data,
    output logic                in_ready,
    input  logic                clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS/2-1:0]   root,
    output logic [BITS/2:0]     rem,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    localparam int RW  = BITS / 2;       // root width
    localparam int RMW = RW + 2;         // internal partial remainder width
    localparam int CW  = $clog2(RW + 1); // iteration counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [BITS-1:0]     rad_q,   rad_d;    // radicand, consumed MSB pair first
    logic [RW-1:0]       proot_q, proot_d;  // partial root
    logic [RMW-1:0]      prem_q,  prem_d;   // partial remainder
    logic [RW-1:0]       root_q,  root_d;   // published root
    logic [RW:0]         rem_q,   rem_d;    // published remainder

    // One digit step: shifted remainder, trial subtrahend and the new root/remainder
    logic [RMW-1:0]      rem_shift;
    logic [RMW-1:0]      trial;
    logic                take;
    logic [RMW-1:0]      rem_next;
    logic [RW-1:0]       root_next;
    logic [RW-1:0]       root_final;

    // Combinational digit-by-digit step, plus optional rounding of the final root
    always_comb begin
        // The partial remainder never exceeds 2*partial_root, so dropping the
        // top two bits of the shifted value loses nothing.
        rem_shift = RMW'({prem_q, rad_q[BITS-1 -: 2]});
        trial     = {proot_q, 2'b01};
        take      = (rem_shift >= trial);
        rem_next  = take ? (rem_shift - trial) : rem_shift;
        root_next = {proot_q[RW-2:0], take};
`ifdef ISQRT_ROUND_EN
        // Round to nearest: go up when rem > root. Hold at all-ones so the
        // result never wraps.
        if ((rem_next > {2'b00, root_next}) && !(&root_next)) begin
            root_final = root_next + RW'(1);
        end else begin
            root_final = root_next;
        end
`else
        root_final = root_next;
`endif
    end

    // Next-state logic and datapath updates for the IDLE/CALC/DONE sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rad_d   = rad_q;
        proot_d = proot_q;
        prem_d  = prem_q;
        root_d  = root_q;
        rem_d   = rem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rad_d   = in_data;
                    proot_d = '0;
                    prem_d  = '0;
                    cnt_d   = CW'(RW);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rad_d   = rad_q << 2;
                proot_d = root_next;
                prem_d  = rem_next;
                cnt_d   = cnt_q - CW'(1);
                // The last iteration publishes the result as DONE is entered
                if (cnt_q == CW'(1)) begin
                    root_d  = root_final;
                    rem_d   = rem_next[RW:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything. The published result is left untouched.
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers, cleared asynchronously by reset_n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rad_q   <= '0;
            proot_q <= '0;
            prem_q  <= '0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            proot_q <= proot_d;
            prem_q  <= prem_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign root      = root_q;
    assign rem       = rem_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_count_isqrt_unit.sv
// Bench for count_isqrt_unit (BITS=32): directed radicands with hand-computed results.
module tb_count_isqrt_unit;

  localparam int BITS = 32;
  localparam int RW   = BITS / 2;
  localparam int W    = RW + RW + 1;   // packed {root, rem}

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic            clear;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   root;
  logic [RW:0]     rem;
  logic            busy;
  logic [1:0]      state_dbg;

  count_isqrt_unit #(.BITS(BITS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int accept_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on out_valid rise, result compare on each output transfer
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov)
        check("latency", 64'(cyc - accept_cyc), 64'(RW));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(1), 64'(0));
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("root", 64'(root), 64'(e[W-1 -: RW]));
          check("rem",  64'(rem),  64'(e[RW:0]));
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [BITS-1:0] d, input logic [RW-1:0] r_floor,
                      input logic [RW-1:0] r_round, input logic [RW:0] rm, input bit push);
    @(negedge clk);
    check("in_ready_before_send", 64'(in_ready), 64'(1));
    if (push) begin
`ifdef ISQRT_ROUND_EN
      exp_q.push_back({r_round, rm});
`else
      exp_q.push_back({r_floor, rm});
`endif
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready && exp_q.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("return_to_idle", 64'(in_ready && exp_q.size() == 0), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_root",      64'(root),      64'(0));
    check("rst_rem",       64'(rem),       64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // radicand, floor root, rounded root, remainder
    send(32'd0,          16'd0,     16'd0,     17'd0,      1'b1); wait_idle();
    send(32'd1000000,    16'd1000,  16'd1000,  17'd0,      1'b1); wait_idle();
    send(32'd99,         16'd9,     16'd10,    17'd18,     1'b1); wait_idle();
    send(32'hFFFFFFFF,   16'd65535, 16'd65535, 17'd131070, 1'b1); wait_idle();
    send(32'hFFFE0001,   16'd65535, 16'd65535, 17'd0,      1'b1); wait_idle();
    send(32'd95,         16'd9,     16'd10,    17'd14,     1'b1); wait_idle();
    send(32'd90,         16'd9,     16'd9,     17'd9,      1'b1); wait_idle();
    send(32'd2,          16'd1,     16'd1,     17'd1,      1'b1); wait_idle();
    send(32'd3,          16'd1,     16'd2,     17'd2,      1'b1); wait_idle();

    // Backpressure: hold the result for 20 cycles, try a second radicand meanwhile
    out_ready = 1'b0;
    send(32'd144, 16'd12, 16'd12, 17'd0, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) begin
        in_valid = 1'b1;
        in_data  = 32'd9999;
      end else begin
        in_valid = 1'b0;
      end
      check("bp_root",      64'(root),      64'(12));
      check("bp_rem",       64'(rem),       64'(0));
      check("bp_in_ready",  64'(in_ready),  64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle();
    send(32'd169, 16'd13, 16'd13, 17'd0, 1'b1); wait_idle();

    // clear during the 5th iteration
    send(32'd50000, 16'd0, 16'd0, 17'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clr_busy",      64'(busy),      64'(0));
    check("clr_in_ready",  64'(in_ready),  64'(1));
    check("clr_out_valid", 64'(out_valid), 64'(0));
    check("clr_root_held", 64'(root),      64'(13));
    check("clr_rem_held",  64'(rem),       64'(0));
    repeat (20) @(negedge clk);
    check("clr_no_output", 64'(out_valid), 64'(0));

    // reset pulse in the middle of CALC
    send(32'd400, 16'd0, 16'd0, 17'd0, 1'b0);
    repeat (6) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_root",      64'(root),      64'(0));
    check("rstmid_rem",       64'(rem),       64'(0));
    check("rstmid_in_ready",  64'(in_ready),  64'(1));
    check("rstmid_busy",      64'(busy),      64'(0));
    check("rstmid_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    send(32'd400, 16'd20, 16'd20, 17'd0, 1'b1); wait_idle();

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
